// File: rtl/ieee_fcmp_pkg.sv
// Shared encodings for the pipelined IEEE 754 compare/min-max unit:
// operation codes, operand classes and the canonical quiet NaN.
package ieee_fcmp_pkg;

   localparam logic [2:0] OP_FEQ  = 3'd0;
   localparam logic [2:0] OP_FLT  = 3'd1;
   localparam logic [2:0] OP_FLE  = 3'd2;
   localparam logic [2:0] OP_FMIN = 3'd3;
   localparam logic [2:0] OP_FMAX = 3'd4;

   typedef enum logic [2:0] {
      FC_ZERO,
      FC_SUBNORMAL,
      FC_NORMAL,
      FC_INF,
      FC_QNAN,
      FC_SNAN
   } fp_class_e;

   // Positive quiet NaN with only the mantissa MSB set; callers truncate to their width.
   function automatic logic [127:0] canon_qnan(input int unsigned exp_w, input int unsigned mant_w);
      logic [127:0] exp_ones;
      exp_ones = (128'd1 << exp_w) - 128'd1;
      return (exp_ones << mant_w) | (128'd1 << (mant_w - 1));
   endfunction

endpackage

// File: rtl/ieee_fclass.sv
// Combinational classifier for one IEEE 754 operand. Only the exponent and
// mantissa fields are needed, so the sign bit is not part of the interface.
module ieee_fclass
   import ieee_fcmp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23
) (
   input  logic [EXP_WIDTH+MANT_WIDTH-1:0] i_mag,
   output fp_class_e                       o_class
);

   logic [EXP_WIDTH-1:0]  w_exp;
   logic [MANT_WIDTH-1:0] w_mant;

   assign w_exp  = i_mag[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
   assign w_mant = i_mag[MANT_WIDTH-1:0];

   always_comb begin
      o_class = FC_NORMAL;
      if (w_exp == '0) begin
         o_class = (w_mant == '0) ? FC_ZERO : FC_SUBNORMAL;
      end else if (&w_exp) begin
         if (w_mant == '0)
            o_class = FC_INF;
         else if (w_mant[MANT_WIDTH-1])
            o_class = FC_QNAN;
         else
            o_class = FC_SNAN;
      end
   end

endmodule

// File: rtl/ieee_fcmp_pipe.sv
// Two-stage IEEE 754 compare/min-max unit with valid/ready flow control.
// Stage 1 classifies and captures operands; stage 2 orders, selects and registers results.
module ieee_fcmp_pipe
   import ieee_fcmp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_op,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 out_gt,
   output logic                 out_lt,
   output logic                 out_eq,
   output logic                 out_un,
   output logic                 out_invalid,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam logic [WIDTH-1:0] QNAN = WIDTH'(canon_qnan(EXP_WIDTH, MANT_WIDTH));

   // Stage 1 registers
   logic                 r_s1_valid;
   logic [2:0]           r_s1_op;
   logic [WIDTH-1:0]     r_s1_a;
   logic [WIDTH-1:0]     r_s1_b;
   logic [TAG_WIDTH-1:0] r_s1_tag;
   fp_class_e            r_s1_cls_a;
   fp_class_e            r_s1_cls_b;

   // Stage 2 (output) registers
   logic                 r_s2_valid;
   logic [WIDTH-1:0]     r_result;
   logic                 r_gt;
   logic                 r_lt;
   logic                 r_eq;
   logic                 r_un;
   logic                 r_invalid;
   logic [TAG_WIDTH-1:0] r_tag;

   fp_class_e            w_cls_a;
   fp_class_e            w_cls_b;
   logic                 w_s1_load;
   logic                 w_s2_load;

   assign w_s2_load = !r_s2_valid || out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign in_ready  = w_s1_load;

   ieee_fclass #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_fclass_a (
      .i_mag   (in_a[WIDTH-2:0]),
      .o_class (w_cls_a)
   );

   ieee_fclass #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_fclass_b (
      .i_mag   (in_b[WIDTH-2:0]),
      .o_class (w_cls_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
         r_s1_cls_a <= FC_ZERO;
         r_s1_cls_b <= FC_ZERO;
      end else if (w_s1_load) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_op    <= in_op;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_tag   <= in_tag;
            r_s1_cls_a <= w_cls_a;
            r_s1_cls_b <= w_cls_b;
         end
      end
   end

   // Stage 2 combinational ordering
   logic             w_sign_a;
   logic             w_sign_b;
   logic             w_a_nan;
   logic             w_b_nan;
   logic             w_a_snan;
   logic             w_b_snan;
   logic             w_both_zero;
   logic             w_mag_eq;
   logic             w_borrow;
   logic [WIDTH-1:0] w_diff;
   logic             w_gt;
   logic             w_lt;
   logic             w_eq;
   logic             w_un;
   logic [WIDTH-1:0] w_result;
   logic             w_invalid;

   assign w_sign_a    = r_s1_a[WIDTH-1];
   assign w_sign_b    = r_s1_b[WIDTH-1];
   assign w_a_nan     = (r_s1_cls_a == FC_QNAN) || (r_s1_cls_a == FC_SNAN);
   assign w_b_nan     = (r_s1_cls_b == FC_QNAN) || (r_s1_cls_b == FC_SNAN);
   assign w_a_snan    = (r_s1_cls_a == FC_SNAN);
   assign w_b_snan    = (r_s1_cls_b == FC_SNAN);
   assign w_both_zero = (r_s1_cls_a == FC_ZERO) && (r_s1_cls_b == FC_ZERO);
   assign w_mag_eq    = (r_s1_a[WIDTH-2:0] == r_s1_b[WIDTH-2:0]);

   // Zero-extended magnitudes leave the MSB of the difference as the borrow (|a| < |b|).
   assign w_diff   = {1'b0, r_s1_a[WIDTH-2:0]} - {1'b0, r_s1_b[WIDTH-2:0]};
   assign w_borrow = w_diff[WIDTH-1];

   always_comb begin
      w_gt = 1'b0;
      w_lt = 1'b0;
      w_eq = 1'b0;
      w_un = 1'b0;
      if (w_a_nan || w_b_nan) begin
         w_un = 1'b1;
      end else if (w_both_zero) begin
         w_eq = 1'b1;
      end else if (w_sign_a != w_sign_b) begin
         if (w_sign_a)
            w_lt = 1'b1;
         else
            w_gt = 1'b1;
      end else if (w_mag_eq) begin
         w_eq = 1'b1;
      end else if (w_borrow ^ w_sign_a) begin
         w_lt = 1'b1;
      end else begin
         w_gt = 1'b1;
      end
   end

   always_comb begin
      w_result  = '0;
      w_invalid = 1'b0;
      case (r_s1_op)
         OP_FEQ: begin
            w_result  = WIDTH'(w_eq);
            w_invalid = w_a_snan || w_b_snan;
         end
         OP_FLT: begin
            w_result  = WIDTH'(w_lt);
            w_invalid = w_a_nan || w_b_nan;
         end
         OP_FLE: begin
            w_result  = WIDTH'(w_lt || w_eq);
            w_invalid = w_a_nan || w_b_nan;
         end
         OP_FMIN: begin
            w_invalid = w_a_snan || w_b_snan;
            if (w_a_nan && w_b_nan)
               w_result = QNAN;
            else if (w_a_nan)
               w_result = r_s1_b;
            else if (w_b_nan)
               w_result = r_s1_a;
            else if (w_eq)
               w_result = w_sign_a ? r_s1_a : r_s1_b;  // prefers -0 over +0
            else
               w_result = w_lt ? r_s1_a : r_s1_b;
         end
         OP_FMAX: begin
            w_invalid = w_a_snan || w_b_snan;
            if (w_a_nan && w_b_nan)
               w_result = QNAN;
            else if (w_a_nan)
               w_result = r_s1_b;
            else if (w_b_nan)
               w_result = r_s1_a;
            else if (w_eq)
               w_result = w_sign_a ? r_s1_b : r_s1_a;
            else
               w_result = w_gt ? r_s1_a : r_s1_b;
         end
         default: begin
            w_result  = '0;
            w_invalid = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_gt       <= 1'b0;
         r_lt       <= 1'b0;
         r_eq       <= 1'b0;
         r_un       <= 1'b0;
         r_invalid  <= 1'b0;
         r_tag      <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result  <= w_result;
            r_gt      <= w_gt;
            r_lt      <= w_lt;
            r_eq      <= w_eq;
            r_un      <= w_un;
            r_invalid <= w_invalid;
            r_tag     <= r_s1_tag;
         end
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_result  = r_result;
   assign out_gt      = r_gt;
   assign out_lt      = r_lt;
   assign out_eq      = r_eq;
   assign out_un      = r_un;
   assign out_invalid = r_invalid;
   assign out_tag     = r_tag;

endmodule

// File: tb/tb_ieee_fcmp_pipe.sv
// Directed self-checking bench for ieee_fcmp_pipe: single ops with hand-computed
// results, a backpressured stream with in-order tag checks, and mid-stream reset.
module tb_ieee_fcmp_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_gt;
   logic        out_lt;
   logic        out_eq;
   logic        out_un;
   logic        out_invalid;
   logic [3:0]  out_tag;

   int checks = 0;
   int errors = 0;

   logic [31:0] g_res;
   logic [3:0]  g_ord;
   logic        g_inv;
   logic [3:0]  g_tag;

   always #5 clk = ~clk;

   ieee_fcmp_pipe #(.WIDTH(32), .EXP_WIDTH(8), .MANT_WIDTH(23), .TAG_WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_gt      (out_gt),
      .out_lt      (out_lt),
      .out_eq      (out_eq),
      .out_un      (out_un),
      .out_invalid (out_invalid),
      .out_tag     (out_tag)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", name, got, exp);
      end
   endtask

   // Issue one op into an idle pipe with out_ready=1 and capture its result.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk("result_arrived", 32'(out_valid), 32'd1);
      g_res = out_result;
      g_ord = {out_gt, out_lt, out_eq, out_un};
      g_inv = out_invalid;
      g_tag = out_tag;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  s_op  [8];
      logic [31:0] s_a   [8];
      logic [31:0] s_b   [8];
      logic [31:0] s_res [8];
      logic        s_inv [8];
      int          idx;
      int          ncons;
      int          cyc;
      logic        prev_stall;
      logic [31:0] prev_res;
      logic [31:0] prev_misc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_ordering", 32'({out_gt, out_lt, out_eq, out_un}), 32'd0);
      chk("rst_invalid", 32'(out_invalid), 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      rst_n = 1'b1;

      // Basic compare: 1.0 < 2.0
      run_op(3'd1, 32'h3F800000, 32'h40000000, 4'd3);
      chk("flt_basic_res", g_res, 32'd1);
      chk("flt_basic_ord", 32'(g_ord), 32'b0100);
      chk("flt_basic_inv", 32'(g_inv), 32'd0);
      chk("flt_basic_tag", 32'(g_tag), 32'd3);

      // -0 == +0
      run_op(3'd0, 32'h80000000, 32'h00000000, 4'd4);
      chk("feq_zero_res", g_res, 32'd1);
      chk("feq_zero_ord", 32'(g_ord), 32'b0010);
      chk("feq_zero_inv", 32'(g_inv), 32'd0);

      // FEQ with sNaN signals invalid
      run_op(3'd0, 32'h7F800001, 32'h00000000, 4'd5);
      chk("feq_snan_res", g_res, 32'd0);
      chk("feq_snan_ord", 32'(g_ord), 32'b0001);
      chk("feq_snan_inv", 32'(g_inv), 32'd1);

      // FEQ with qNaN is quiet
      run_op(3'd0, 32'h7FC00000, 32'h7FC00000, 4'd6);
      chk("feq_qnan_res", g_res, 32'd0);
      chk("feq_qnan_inv", 32'(g_inv), 32'd0);

      // FLE is signalling on qNaN
      run_op(3'd2, 32'h7FC00000, 32'h00000000, 4'd7);
      chk("fle_qnan_res", g_res, 32'd0);
      chk("fle_qnan_inv", 32'(g_inv), 32'd1);

      // FLE equality
      run_op(3'd2, 32'h40400000, 32'h40400000, 4'd8);
      chk("fle_eq_res", g_res, 32'd1);

      // Signed zeros in min/max, both operand orders
      run_op(3'd3, 32'h00000000, 32'h80000000, 4'd9);
      chk("fmin_zero_res", g_res, 32'h80000000);
      run_op(3'd4, 32'h80000000, 32'h00000000, 4'd10);
      chk("fmax_zero_res", g_res, 32'h00000000);

      // One NaN returns the other operand
      run_op(3'd4, 32'h7FC00000, 32'hC0400000, 4'd11);
      chk("fmax_qnan_res", g_res, 32'hC0400000);
      chk("fmax_qnan_inv", 32'(g_inv), 32'd0);

      // Both NaN returns canonical qNaN; sNaN signals
      run_op(3'd3, 32'h7FC00000, 32'h7F800001, 4'd12);
      chk("fmin_2nan_res", g_res, 32'h7FC00000);
      chk("fmin_2nan_inv", 32'(g_inv), 32'd1);
      run_op(3'd4, 32'hFFC12345, 32'h7FE00000, 4'd13);
      chk("fmax_2nan_res", g_res, 32'h7FC00000);

      // Negative operands: -1 > -2
      run_op(3'd1, 32'hBF800000, 32'hC0000000, 4'd14);
      chk("flt_neg_res", g_res, 32'd0);
      chk("flt_neg_ord", 32'(g_ord), 32'b1000);

      // -inf vs smallest positive subnormal
      run_op(3'd4, 32'hFF800000, 32'h00000001, 4'd15);
      chk("fmax_inf_res", g_res, 32'h00000001);
      chk("fmax_inf_ord", 32'(g_ord), 32'b0100);

      // Subnormals compared by raw magnitude
      run_op(3'd3, 32'h00000003, 32'h00000002, 4'd1);
      chk("fmin_sub_res", g_res, 32'h00000002);
      chk("fmin_sub_ord", 32'(g_ord), 32'b1000);

      // Reserved op
      run_op(3'd6, 32'h3F800000, 32'h40000000, 4'd2);
      chk("rsvd_res", g_res, 32'd0);
      chk("rsvd_inv", 32'(g_inv), 32'd1);
      chk("rsvd_ord", 32'(g_ord), 32'b0100);

      // Backpressured stream of 8 ops, tags 0..7
      s_op  = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6, 3'd1, 3'd4};
      s_a   = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00000001};
      s_b   = '{32'h40000000, 32'h40000000, 32'h40000000, 32'hBF800000,
                32'hBF800000, 32'h40000000, 32'h3F800000, 32'h00000002};
      s_res = '{32'd1, 32'd1, 32'd0, 32'hBF800000,
                32'h3F800000, 32'd0, 32'd0, 32'h00000002};
      s_inv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      idx        = 0;
      ncons      = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_res   = '0;
      prev_misc  = '0;
      while (ncons < 8 && cyc < 200) begin
         @(negedge clk);
         if (prev_stall) begin
            chk("stall_result", out_result, prev_res);
            chk("stall_misc", {22'd0, out_valid, out_invalid, out_gt, out_lt, out_eq, out_un, out_tag},
                prev_misc);
         end
         out_ready = ((cyc / 2) % 2) == 0;
         if (idx < 8) begin
            in_valid = 1'b1;
            in_op    = s_op[idx];
            in_a     = s_a[idx];
            in_b     = s_b[idx];
            in_tag   = 4'(idx);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            chk("stream_tag", 32'(out_tag), 32'(ncons));
            chk("stream_res", out_result, s_res[ncons]);
            chk("stream_inv", 32'(out_invalid), 32'(s_inv[ncons]));
            ncons++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = out_result;
         prev_misc  = {22'd0, out_valid, out_invalid, out_gt, out_lt, out_eq, out_un, out_tag};
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", 32'(ncons), 32'd8);
      repeat (3) begin
         @(negedge clk);
         chk("stream_no_dup", 32'(out_valid), 32'd0);
      end

      // Reset with two ops in flight
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 3'd1;
      in_a     = 32'h3F800000;
      in_b     = 32'h40000000;
      in_tag   = 4'd9;
      @(negedge clk);
      in_op    = 3'd0;
      in_tag   = 4'd10;
      @(negedge clk);
      in_valid = 1'b0;
      chk("midrst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_stale", 32'(out_valid), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ieee_fcmp_pipe.md
# ieee_fcmp_pipe

Pipelined, parametrised IEEE 754 compare/min-max unit. It accepts one operand pair per cycle over a valid/ready handshake and returns either a compare result or a selected operand two cycles later. Each result carries a full ordering vector and an invalid flag. It sits between the operand-issue stage and the result-writeback arbiter of the FP datapath, and supersedes the purely combinational comparator.

## Interface
- WIDTH, 32, total float width
- EXP_WIDTH, 8, exponent field width
- MANT_WIDTH, 23, mantissa field width; WIDTH must equal 1+EXP_WIDTH+MANT_WIDTH
- TAG_WIDTH, 4, opaque tag passed through alongside the operation

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- in_op  in  3  0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX; 5–7 reserved
- in_a, in_b  in  WIDTH  operands
- in_tag  in  TAG_WIDTH  pass-through tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_result  out  WIDTH  compare: zero-extended boolean; FMIN/FMAX: selected value
- out_gt, out_lt, out_eq, out_un  out  1 each  ordering of a vs b, one-hot
- out_invalid  out  1  IEEE invalid-operation flag
- out_tag  out  TAG_WIDTH  tag of this result

## Operation
Stage 1 classifies each operand and registers the class, op, operands and tag. The classes are: zero, subnormal, normal, inf, qNaN and sNaN.
- sNaN: exponent is all ones, mantissa MSB is 0, and the mantissa is nonzero.
- qNaN: exponent is all ones and mantissa MSB is 1.

Stage 2 computes the ordering and the result, then registers the outputs.

Ordering:
- If either operand is NaN, only out_un=1.
- +0 and -0 are equal.
- Infinities are ordered by sign.
- Opposite signs: the positive operand is greater.
- Same sign: compare the {exp, mant} magnitudes, using a WIDTH-bit subtraction whose MSB is the borrow. The sense is inverted when both operands are negative.
- Subnormals are compared as raw magnitude, with no flush.

FEQ:
- result = eq.
- invalid only if an operand is sNaN.

FLT and FLE (signalling compares):
- result = lt, or lt|eq for FLE.
- invalid if either operand is NaN, quiet or signalling.

FMIN and FMAX:
- One operand NaN: return the other operand.
- Both operands NaN: return the canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0).
- FMIN(-0,+0) = -0 and FMAX(-0,+0) = +0, in either operand order.
- Otherwise return the smaller or larger operand bit-exactly.
- invalid if either operand is sNaN.

Reserved op: out_result=0, out_invalid=1, and the ordering vector is still computed.

## Timing
- Reset: in_ready=1. out_valid=0, out_result=0, all ordering bits 0, out_invalid=0, out_tag=0. The stage-1 valid bit is cleared.
- Latency: 2 cycles, from the in_valid&in_ready edge to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Pipeline movement:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2 loads. It is combinational from out_ready, and there is no skid buffer.
- Stall: while out_valid=1 and out_ready=0, every out_* signal holds stable and no data is lost.
- Simultaneous accept and drain in the same cycle is legal and keeps full rate.
- in_* signals are ignored while in_ready=0 or in_valid=0.
- Reset mid-operation discards all in-flight operations immediately and asynchronously.
- Tags leave in order, unchanged.

## Structure
- Package ieee_fcmp_pkg holds:
  - op encodings
  - the fp_class enum
  - the canonical-qNaN constant function, parametrised by EXP_WIDTH and MANT_WIDTH
- Sub-module ieee_fclass: purely combinational, takes one operand and produces its class. Two instances are used, one per operand, in stage 1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release with out_ready=1 → out_valid=0 and in_ready=1. FLT a=0x3F800000, b=0x40000000 → after 2 cycles, out_result=1, out_lt=1, out_invalid=0.
- Zeros and NaN: FEQ a=0x80000000, b=0x00000000 → eq=1, result=1. FEQ a=0x7F800001 (sNaN), b=0 → un=1, result=0, invalid=1. FLE a=0x7FC00000, b=0 → invalid=1.
- Min/max: FMIN(0x00000000, 0x80000000) → 0x80000000. FMAX(0x7FC00000, 0xC0400000) → 0xC0400000, invalid=0. FMIN(0x7FC00000, 0x7F800001) → 0x7FC00000, invalid=1.
- Ordering: FLT(0xBF800000, 0xC0000000) → gt=1, result=0. FMAX(0xFF800000, 0x00000001) → 0x00000001.
- Backpressure: stream 8 back-to-back ops with tags 0–7 while toggling out_ready every 2 cycles → outputs stay stable during stalls, tags emerge 0–7 in order, none lost or duplicated. The reserved op 6 → result=0, invalid=1.
- Reset mid-stream: assert rst_n=0 with 2 ops in flight → out_valid drops asynchronously. After release, no stale results appear.
